// File: rtl/fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// Shared definitions for the FIFO write-port arbiter.
//
// FIFO_param_pkg : FIFO-wide parameters (data width) shared with the FIFO
//                  write-logic block.
// fifo_arb_pkg   : arbiter state encoding, default sizing, requester-id type
//                  and the round-robin pointer increment helper.
// -----------------------------------------------------------------------------
package FIFO_param_pkg;
    localparam int WIDTH = 32;
endpackage

package fifo_arb_pkg;
    import FIFO_param_pkg::WIDTH;

    localparam int WIDTH_DEF   = WIDTH;
    localparam int NUM_REQ_DEF = 4;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    typedef logic [$clog2(NUM_REQ_DEF)-1:0] req_id_t;

    // Next round-robin start position: the requester after id, wrapping at n.
    function automatic int rr_next(input int id, input int n);
        return (id + 1 >= n) ? 0 : id + 1;
    endfunction
endpackage

// File: rtl/fifo_wr_arbiter_pick.sv
// -----------------------------------------------------------------------------
// rr_priority_pick: purely combinational round-robin priority selector.
// Searches req_i starting at rr_ptr_i and moving upward with wrap-around;
// returns the first set position. Shared with the read-side arbiter.
//
// Ports:
//   req_i      in  N    request vector
//   rr_ptr_i   in  IW   position with highest priority this cycle
//   winner_o   out IW   index of the selected request (0 when none)
//   any_req_o  out 1    at least one request bit is set
// -----------------------------------------------------------------------------
module rr_priority_pick
    import fifo_arb_pkg::*;
#(
    parameter  int N  = NUM_REQ_DEF,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] rr_ptr_i,
    output logic [IW-1:0] winner_o,
    output logic          any_req_o
);

    int idx;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise a latch is inferred.
    always_comb begin
        winner_o  = '0;
        any_req_o = |req_i;
        idx       = 0;
        // Walk from the farthest offset down to offset 0 so the position
        // closest to rr_ptr_i is the last (and therefore winning) assignment.
        for (int off = N - 1; off >= 0; off--) begin
            idx = int'(rr_ptr_i) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req_i[idx]) begin
                winner_o = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter: shares one FIFO write port among NUM_REQ producers with
// round-robin arbitration and burst locking. A grant is taken in IDLE (one
// bubble cycle) and held in LOCK until the owner transfers a beat marked last.
// Beats pass through combinationally; nothing is written while fifo_full=1.
//
// Optional feature (macro FIFO_WR_ARBITER_WATCHDOG_EN): an idle-owner watchdog
// releases a grant whose owner stops presenting beats, and pulses arb_timeout.
//
// Ports:
//   CLK           in   1               system clock
//   nRST          in   1               synchronous reset, active HIGH
//   req_valid     in   NUM_REQ         per-requester beat valid
//   req_last      in   NUM_REQ         final beat of a requester's burst
//   req_data      in   NUM_REQ*WIDTH   packed beats, requester i at [i*WIDTH +: WIDTH]
//   req_ready     out  NUM_REQ         beat accepted (one-hot or zero)
//   fifo_full     in   1               FIFO full flag
//   fifo_wr_err   in   1               FIFO write error
//   fifo_wr_en    out  1               FIFO write strobe
//   fifo_wr_data  out  WIDTH           FIFO write data
//   grant_id      out  $clog2(NUM_REQ) current owner, valid while busy=1
//   busy          out  1               a grant is held
//   arb_err       out  1               sticky: write error seen on our write
//   arb_timeout   out  1               (watchdog build only) one-cycle pulse
// -----------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int WIDTH   = WIDTH_DEF,
    parameter  int NUM_REQ = NUM_REQ_DEF,
    parameter  int TIMEOUT = TIMEOUT_DEF,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_last,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     fifo_full,
    input  logic                     fifo_wr_err,
    output logic                     fifo_wr_en,
    output logic [WIDTH-1:0]         fifo_wr_data,
    output logic [IDW-1:0]           grant_id,
    output logic                     busy,
    output logic                     arb_err
`ifdef FIFO_WR_ARBITER_WATCHDOG_EN
    ,
    output logic                     arb_timeout
`endif
);

    arb_state_t     state_q, state_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic           arb_err_q, arb_err_d;

    logic [IDW-1:0] pick_id;
    logic           any_req;
    logic           in_lock;
    logic           owner_valid;
    logic           owner_last;
    logic           wr_en;
    logic [IDW-1:0] next_ptr;

    rr_priority_pick #(
        .N (NUM_REQ)
    ) u_pick (
        .req_i     (req_valid),
        .rr_ptr_i  (rr_ptr_q),
        .winner_o  (pick_id),
        .any_req_o (any_req)
    );

    assign in_lock     = (state_q == LOCK);
    assign owner_valid = req_valid[grant_q];
    assign owner_last  = req_last[grant_q];
    assign next_ptr    = IDW'(rr_next(int'(grant_q), NUM_REQ));

    // The reset term blocks a beat from being accepted in the cycle that
    // abandons the burst, so the producer never sees a half-counted transfer.
    assign wr_en = in_lock & owner_valid & ~fifo_full & ~nRST;

`ifdef FIFO_WR_ARBITER_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wd_cnt_q, wd_cnt_d;
    logic [CW-1:0] wd_cnt_inc;
    logic          timeout_q, timeout_d;

    assign wd_cnt_inc = wd_cnt_q + CW'(1);
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        arb_err_d = arb_err_q | (wr_en & fifo_wr_err);

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = pick_id;
                    state_d = LOCK;
                end
            end
            LOCK: begin
                if (wr_en && owner_last) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef FIFO_WR_ARBITER_WATCHDOG_EN
        wd_cnt_d  = '0;
        timeout_d = 1'b0;
        if (in_lock) begin
            if (wr_en) begin
                wd_cnt_d = '0;
            end else if (!owner_valid && !fifo_full) begin
                // Fire in the idle cycle that brings the count to TIMEOUT-1,
                // so the pulse and IDLE appear together one cycle later.
                if (wd_cnt_inc == CW'(TIMEOUT - 1)) begin
                    state_d   = IDLE;
                    rr_ptr_d  = next_ptr;
                    timeout_d = 1'b1;
                    wd_cnt_d  = '0;
                end else begin
                    wd_cnt_d = wd_cnt_inc;
                end
            end else begin
                // Stalled by full: the owner is not idle, hold the count.
                wd_cnt_d = wd_cnt_q;
            end
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register. Reset here
    // is synchronous and active-high, checked first inside the clocked block.
    always_ff @(posedge CLK) begin
        if (nRST) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            arb_err_q <= 1'b0;
`ifdef FIFO_WR_ARBITER_WATCHDOG_EN
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            arb_err_q <= arb_err_d;
`ifdef FIFO_WR_ARBITER_WATCHDOG_EN
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign fifo_wr_en   = wr_en;
    assign req_ready    = wr_en ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q) : '0;
    assign fifo_wr_data = in_lock ? req_data[int'(grant_q) * WIDTH +: WIDTH] : '0;
    assign grant_id     = grant_q;
    assign busy         = in_lock;
    assign arb_err      = arb_err_q;
`ifdef FIFO_WR_ARBITER_WATCHDOG_EN
    assign arb_timeout  = timeout_q;
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single FIFO write port among NUM_REQ producers.
- Uses round-robin arbitration with burst locking.
- Sits between the producer agents and the FIFO write-logic block: drives fifo_wr_en/fifo_wr_data and observes fifo_full/fifo_wr_err.
- Guarantees starvation-free access and never issues a write while the FIFO reports full.

Parameters:
- WIDTH, 32, data width; must match the FIFO_param_pkg WIDTH.
- NUM_REQ, 4, number of requesters (2..16).
- TIMEOUT, 64, watchdog idle-cycle limit (used only with the optional feature).

Ports:
- CLK  in  1  system clock.
- nRST  in  1  reset. One clock; reset is synchronous and active-high despite the name, sampled on the CLK rising edge.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_last  in  NUM_REQ  marks the final beat of a requester's burst.
- req_data  in  NUM_REQ*WIDTH  packed beat data; requester i occupies bits [i*WIDTH +: WIDTH].
- req_ready  out  NUM_REQ  per-requester beat accepted (one-hot or zero).
- fifo_full  in  1  FIFO full flag.
- fifo_wr_err  in  1  FIFO write error.
- fifo_wr_en  out  1  write strobe to the FIFO.
- fifo_wr_data  out  WIDTH  write data to the FIFO.
- grant_id  out  $clog2(NUM_REQ)  index of the current owner; valid while busy=1.
- busy  out  1  a grant is held (state LOCK).
- arb_err  out  1  sticky: fifo_wr_err was seen coincident with our write.

Behaviour:
- Reset values (nRST=1 at a clock edge): state=IDLE, rr_ptr=0, grant_id=0, busy=0, arb_err=0, watchdog count=0.
- fifo_wr_en=0 and req_ready=0 while in IDLE or under reset.
- States: IDLE and LOCK.
- IDLE:
  - If any req_valid is set, pick the first set bit searching from rr_ptr upward with wrap-around (rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ...).
  - Register it into grant_id and go to LOCK.
  - One arbitration bubble cycle; no transfer occurs in IDLE.
- LOCK handshake (combinational from registered state):
  - fifo_wr_en = req_valid[grant_id] & ~fifo_full.
  - req_ready[grant_id] = fifo_wr_en; all other req_ready bits = 0.
  - fifo_wr_data = req_data slice of grant_id; this holds in LOCK even when not writing. Output 0 in IDLE.
  - A beat transfers in a cycle where fifo_wr_en=1. Zero-latency pass-through.
- LOCK exit:
  - On a transferred beat with req_last[grant_id]=1, go to IDLE and set rr_ptr = grant_id+1 (mod NUM_REQ).
  - Consequence: back-to-back bursts always show one IDLE cycle between them.
- Full:
  - fifo_full=1 stalls the grant: no write, grant is held, data must stay stable at the producer.
  - The arbiter never writes while full, including in the cycle full rises.
- Single-beat burst: req_valid and req_last together on the first accepted beat gives one write, then release.
- A requester dropping valid mid-burst keeps the grant; it is not released without last (see watchdog).
- Requests from non-owners are ignored and see req_ready=0; they must hold valid.
- arb_err: set when fifo_wr_en & fifo_wr_err in the same cycle; cleared only by reset.
- Reset mid-burst: immediate return to IDLE with rr_ptr=0; the partial burst is abandoned and the producer restarts it.

Optional Feature:
- Macro: FIFO_WR_ARBITER_WATCHDOG_EN.
- Defined:
  - Adds output arb_timeout (1 bit, registered, reset 0).
  - Counter increments each LOCK cycle where req_valid[grant_id]=0 and fifo_full=0, and clears on any transfer.
  - When the count reaches TIMEOUT-1, force LOCK→IDLE, advance rr_ptr past the owner, and pulse arb_timeout for 1 cycle.
- Undefined: no counter and no arb_timeout port; the grant is held indefinitely until last.

Decomposition:
- Package fifo_arb_pkg:
  - arb_state_t enum {IDLE, LOCK}.
  - NUM_REQ_DEF = 4.
  - TIMEOUT_DEF = 64.
  - req_id_t = logic [$clog2(NUM_REQ_DEF)-1:0].
  - Imports WIDTH from FIFO_param_pkg.
- Sub-module rr_priority_pick: purely combinational.
  - Inputs: req vector, rr_ptr.
  - Outputs: winner index and any_req.
  - Reusable for the read-side arbiter.

Test Plan:
- Reset and idle: nRST=1 for 2 cycles, req_valid=0 → fifo_wr_en=0, busy=0, req_ready=0, arb_err=0.
- Round-robin fairness:
  - All 4 requesters hold valid, each sending single-beat bursts (last=1).
  - Expected grant order 0,1,2,3,0 with exactly one write every 2 cycles.
  - fifo_wr_data equals each requester's data, e.g. 0xA0+i.
- Burst lock:
  - Requester 2 sends 3 beats 0x11,0x22,0x33 (last on 0x33) while requester 0 also requests.
  - FIFO receives 0x11,0x22,0x33 contiguously, then requester 0 is granted; rr_ptr=3 after release.
- Full backpressure:
  - fifo_full=1 for 5 cycles mid-burst → fifo_wr_en=0 and req_ready=0 for those cycles, grant unchanged.
  - The next beat is written in the cycle full drops.
- Error sticky: assert fifo_wr_err during one write beat → arb_err=1 on the following cycle and stays 1 until reset.
- Watchdog (macro defined, TIMEOUT=8):
  - Owner drops valid mid-burst → arb_timeout pulses on the 8th idle cycle, state returns to IDLE, and the next requester is granted.
